// File: rtl/lif_soma.sv
// Leaky integrate-and-fire soma: sums synapse potentials, fires on threshold,
// then holds off for a refractory window; counts emitted spikes with saturation.
module lif_soma #(
  parameter int unsigned p_width     = 8,
  parameter int unsigned p_nbit      = 8,
  parameter int unsigned p_ninputs   = 4,
  parameter int unsigned p_sum_width = p_width + p_nbit + $clog2(p_ninputs),
  parameter int unsigned p_threshold = 32'h3000,
  parameter int unsigned p_refrac    = 4,
  parameter int unsigned p_cnt_width = 8
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [p_ninputs*(p_width+p_nbit)-1:0]   i_do,
  input  logic                                    i_inhibit,
  output logic                                    o_spike,
  output logic                                    o_busy,
  output logic [p_sum_width-1:0]                  o_sum,
  output logic [p_cnt_width-1:0]                  o_count
);

  localparam int unsigned PW = p_width + p_nbit;
  localparam int unsigned RW = (p_refrac > 0) ? $clog2(p_refrac + 1) : 1;
  localparam logic [p_sum_width-1:0] THR       = p_sum_width'(p_threshold);
  localparam logic [RW-1:0]          REFRAC_LD = RW'(p_refrac);
  localparam logic [p_cnt_width-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_FIRE      = 2'd1,
    ST_REFRAC    = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [RW-1:0]          refrac_cnt, refrac_cnt_next;
  logic [p_sum_width-1:0] sum_c;

  // Membrane sum: zero-extended lanes, accumulator wide enough to never wrap
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < int'(p_ninputs); k++) begin
      sum_c = sum_c + p_sum_width'(i_do[k*PW +: PW]);
    end
  end

  // Next-state logic; refractory entry collapses to INTEGRATE when p_refrac is zero
  always_comb begin
    state_next      = state;
    refrac_cnt_next = refrac_cnt;
    case (state)
      ST_INTEGRATE: begin
        if (i_inhibit) begin
          if (p_refrac != 0) begin
            state_next      = ST_REFRAC;
            refrac_cnt_next = REFRAC_LD;
          end
        end else if (o_sum >= THR) begin
          state_next = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (p_refrac != 0) begin
          state_next      = ST_REFRAC;
          refrac_cnt_next = REFRAC_LD;
        end else begin
          state_next = ST_INTEGRATE;
        end
      end
      ST_REFRAC: begin
        if (i_inhibit) begin
          refrac_cnt_next = REFRAC_LD;
        end else if (refrac_cnt == RW'(1)) begin
          state_next      = ST_INTEGRATE;
          refrac_cnt_next = '0;
        end else begin
          refrac_cnt_next = refrac_cnt - RW'(1);
        end
      end
      default: begin
        state_next      = ST_INTEGRATE;
        refrac_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_INTEGRATE;
      refrac_cnt <= '0;
    end else begin
      state      <= state_next;
      refrac_cnt <= refrac_cnt_next;
    end
  end

  // Outputs registered from next-state so they track the state register exactly
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sum   <= '0;
      o_spike <= 1'b0;
      o_busy  <= 1'b0;
      o_count <= '0;
    end else begin
      o_sum   <= sum_c;
      o_spike <= (state_next == ST_FIRE);
      o_busy  <= (state_next != ST_INTEGRATE);
      if (state_next == ST_FIRE && o_count != CNT_MAX) begin
        o_count <= o_count + p_cnt_width'(1);
      end
    end
  end

endmodule

// File: tb/tb_lif_soma.sv
// Scoreboard bench for lif_soma: three parameterizations driven in lockstep,
// checked every cycle against a cycle-count reference model.
module tb_lif_soma;

  localparam int THR = 32'h3000;

  typedef struct packed {
    logic [2:0][17:0] sum;
    logic [2:0]       spk;
    logic [2:0]       bsy;
    logic [2:0][7:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        inh;
  logic [63:0] dvec;

  logic        spk_o [3];
  logic        bsy_o [3];
  logic [17:0] sum_o [3];
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;
  logic [7:0]  cnt2;

  int errors = 0;
  int checks = 0;

  // Reference state: registered sum, spike flag, remaining refractory cycles, spike count
  int m_sum  [3];
  int m_hold [3];
  int m_cnt  [3];
  bit m_spk  [3];
  int refr   [3] = '{4, 4, 0};
  int cmax   [3] = '{255, 3, 255};

  exp_t q[$];
  exp_t e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lif_soma u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_do(dvec), .i_inhibit(inh),
    .o_spike(spk_o[0]), .o_busy(bsy_o[0]), .o_sum(sum_o[0]), .o_count(cnt0)
  );

  lif_soma #(.p_cnt_width(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_do(dvec), .i_inhibit(inh),
    .o_spike(spk_o[1]), .o_busy(bsy_o[1]), .o_sum(sum_o[1]), .o_count(cnt1)
  );

  lif_soma #(.p_refrac(0)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_do(dvec), .i_inhibit(inh),
    .o_spike(spk_o[2]), .o_busy(bsy_o[2]), .o_sum(sum_o[2]), .o_count(cnt2)
  );

  function automatic int cnt_of(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic logic [63:0] lanes(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string nm, input int i, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%0h exp=%0h", nm, i, $time, got, exp_v);
    end
  endtask

  // One clock of the behavioural model, applied to what the next edge will produce
  task automatic model_step(input bit r, input bit ih, input logic [63:0] d);
    int s;
    exp_t x;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'(d[k*16 +: 16]);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_sum[i] = 0; m_hold[i] = 0; m_cnt[i] = 0; m_spk[i] = 1'b0;
      end else begin
        if (m_spk[i]) begin
          m_spk[i]  = 1'b0;
          m_hold[i] = refr[i];
        end else if (m_hold[i] > 0) begin
          m_hold[i] = ih ? refr[i] : m_hold[i] - 1;
        end else if (ih) begin
          m_hold[i] = refr[i];
        end else if (m_sum[i] >= THR) begin
          m_spk[i] = 1'b1;
          if (m_cnt[i] < cmax[i]) m_cnt[i]++;
        end
        m_sum[i] = s;
      end
      x.sum[i] = 18'(m_sum[i]);
      x.spk[i] = m_spk[i];
      x.bsy[i] = m_spk[i] || (m_hold[i] > 0);
      x.cnt[i] = 8'(m_cnt[i]);
    end
    q.push_back(x);
  endtask

  task automatic drive(input bit r, input bit ih, input logic [63:0] d, input int n);
    bit rise;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      #1;
      rise = r && !rst;
      rst  = r;
      inh  = ih;
      dvec = d;
      model_step(r, ih, d);
      if (rise) begin
        #1;
        for (int i = 0; i < 3; i++) begin
          check("rst_spike", i, int'(spk_o[i]), 0);
          check("rst_busy",  i, int'(bsy_o[i]), 0);
          check("rst_sum",   i, int'(sum_o[i]), 0);
          check("rst_count", i, cnt_of(i), 0);
        end
      end
    end
  endtask

  // Monitor: every negedge compares the DUTs against the oldest queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < 3; i++) begin
        check("sum",   i, int'(sum_o[i]), int'(e.sum[i]));
        check("spike", i, int'(spk_o[i]), int'(e.spk[i]));
        check("busy",  i, int'(bsy_o[i]), int'(e.bsy[i]));
        check("count", i, cnt_of(i),      int'(e.cnt[i]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    bit          rr, ri;
    rst  = 1'b1;
    inh  = 1'b0;
    dvec = lanes(16'h0100, 16'h0200, 16'h0300, 16'h0400);

    drive(1, 0, lanes(16'h0100, 16'h0200, 16'h0300, 16'h0400), 3);
    drive(0, 0, lanes(16'h0100, 16'h0200, 16'h0300, 16'h0400), 2);
    drive(0, 0, '0, 2);

    // Exactly at threshold, held
    drive(0, 0, lanes(16'h2000, 16'h1000, 16'h0000, 16'h0000), 16);
    drive(0, 0, '0, 8);

    // One below threshold
    drive(0, 0, lanes(16'h2FFF, 16'h0000, 16'h0000, 16'h0000), 20);

    // Inhibit on the compare cycle, then again on the last refractory cycle
    drive(0, 0, lanes(16'h3000, 16'h0000, 16'h0000, 16'h0000), 1);
    drive(0, 1, lanes(16'h3000, 16'h0000, 16'h0000, 16'h0000), 1);
    drive(0, 0, '0, 3);
    drive(0, 1, '0, 1);
    drive(0, 0, '0, 8);

    // Maximum sum, counter saturation
    drive(0, 0, {4{16'hFFFF}}, 30);

    // Reset in the middle of the refractory window
    drive(0, 0, '0, 8);
    drive(0, 0, {4{16'hFFFF}}, 4);
    drive(1, 0, {4{16'hFFFF}}, 2);
    drive(0, 0, '0, 3);

    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 9) == 0) rd[k*16 +: 16] = 16'hFFFF;
        else rd[k*16 +: 16] = 16'($urandom_range(0, 32'h1800));
      end
      ri = ($urandom_range(0, 7) == 0);
      rr = ($urandom_range(0, 49) == 0);
      drive(rr, ri, rd, 1);
    end

    drive(0, 0, '0, 2);
    @(negedge clk);
    #2;
    check("drain", 0, q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
